// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchroniser, mid-bit sampling FSM, LSB-first reassembly,
// stop-bit check with single-cycle valid / framing-error strobes.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic [2:0]           r_state;
   logic [CW-1:0]        r_clk_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_busy;

   logic                 w_rx_s;
   logic [DATA_BITS:0]   w_cat;
   logic                 w_cnt_last;

   assign w_rx_s     = r_sync2;
   // New bit enters at the MSB so that after DATA_BITS shifts bit 0 sits at the LSB.
   assign w_cat      = {w_rx_s, r_shift};
   assign w_cnt_last = (r_clk_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state   <= S_START;
                  r_clk_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            S_START: begin
               if (r_clk_cnt == CNT_MID) begin
                  r_clk_cnt <= '0;
                  if (!w_rx_s) begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (w_cnt_last) begin
                  r_clk_cnt <= '0;
                  r_shift   <= w_cat[DATA_BITS:1];
                  if (r_bit_idx == IDX_LAST) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + BW'(1);
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end
            // IDLE is re-entered at mid-stop so a following start edge is never missed.
            S_STOP: begin
               if (w_cnt_last) begin
                  r_clk_cnt <= '0;
                  if (w_rx_s) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= S_WAIT;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_clk_cnt <= '0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_ferr;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (16 clk per bit, 8 data bits): reset, frame, glitch, framing
// error, back-to-back frames and mid-frame reset.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int         cyc     = 0;
   int         n_valid = 0;
   int         n_ferr  = 0;
   int         n_both  = 0;
   int         v_cyc [0:3];
   logic [7:0] v_dat [0:3];

   uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Strobe monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         if (n_valid < 4) begin
            v_cyc[n_valid] = cyc;
            v_dat[n_valid] = rx_data;
         end
         n_valid++;
      end
      if (frame_err) n_ferr++;
      if (rx_valid && frame_err) n_both++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      n_valid = 0;
      n_ferr  = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(16);
      end
      rx = stop;
      tick(16);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      tick(3);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_state: busy=%b valid=%b ferr=%b data=%h, want 0 0 0 00",
                  busy, rx_valid, frame_err, rx_data);
      end
      clear_mon();
      tick(100);
      checks++;
      if (busy !== 1'b0 || n_valid !== 0 || n_ferr !== 0 || rx_data !== 8'h00) begin
         failures++;
         $display("FAIL idle_100: busy=%b valid=%0d ferr=%0d data=%h, want 0 0 0 00",
                  busy, n_valid, n_ferr, rx_data);
      end
   endtask

   task automatic test_frame();
      int t_fall;
      clear_mon();
      t_fall = cyc;
      send_byte(8'hA5, 1'b1);
      tick(10);
      checks++;
      if (n_valid !== 1 || n_ferr !== 0 || v_dat[0] !== 8'hA5 || rx_data !== 8'hA5) begin
         failures++;
         $display("FAIL frame_a5: valid=%0d ferr=%0d data=%h, want 1 0 a5", n_valid, n_ferr, rx_data);
      end
      // Fall to strobe: 2 sync + 1 idle detect + 8 half start bit + 9*16 bits = 155 edges.
      checks++;
      if (v_cyc[0] - t_fall !== 155) begin
         failures++;
         $display("FAIL latency: got %0d, want 155", v_cyc[0] - t_fall);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_frame: got %b, want 0", busy);
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      tick(4);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL glitch_start: busy=%b, want 1", busy);
      end
      rx = 1'b1;
      tick(12);
      checks++;
      if (busy !== 1'b0 || n_valid !== 0 || n_ferr !== 0) begin
         failures++;
         $display("FAIL glitch_reject: busy=%b valid=%0d ferr=%0d, want 0 0 0", busy, n_valid, n_ferr);
      end
      tick(20);
   endtask

   task automatic test_frame_err();
      clear_mon();
      send_byte(8'h3C, 1'b0);
      rx = 1'b0;
      tick(40);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL break_hold: busy=%b, want 1", busy);
      end
      rx = 1'b1;
      tick(20);
      checks++;
      if (n_ferr !== 1 || n_valid !== 0 || rx_data !== 8'hA5 || busy !== 1'b0) begin
         failures++;
         $display("FAIL frame_err: ferr=%0d valid=%0d data=%h busy=%b, want 1 0 a5 0",
                  n_ferr, n_valid, rx_data, busy);
      end
      clear_mon();
      send_byte(8'h5A, 1'b1);
      tick(10);
      checks++;
      if (n_valid !== 1 || n_ferr !== 0 || rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL after_err_5a: valid=%0d ferr=%0d data=%h, want 1 0 5a", n_valid, n_ferr, rx_data);
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      tick(10);
      checks++;
      if (n_valid !== 2 || n_ferr !== 0) begin
         failures++;
         $display("FAIL b2b_count: valid=%0d ferr=%0d, want 2 0", n_valid, n_ferr);
      end
      checks++;
      if (v_dat[0] !== 8'h00 || v_dat[1] !== 8'hFF) begin
         failures++;
         $display("FAIL b2b_data: got %h %h, want 00 ff", v_dat[0], v_dat[1]);
      end
      checks++;
      if (v_cyc[1] - v_cyc[0] !== 160) begin
         failures++;
         $display("FAIL b2b_spacing: got %0d, want 160", v_cyc[1] - v_cyc[0]);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] d;
      d = 8'h81;
      clear_mon();
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         tick(16);
      end
      rx = d[4];
      tick(8);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_frame_busy: got %b, want 1", busy);
      end
      rst = 1'b1;
      rx  = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_abort: busy=%b valid=%b ferr=%b, want 0 0 0", busy, rx_valid, frame_err);
      end
      tick(40);
      checks++;
      if (n_valid !== 0 || n_ferr !== 0) begin
         failures++;
         $display("FAIL rst_no_strobe: valid=%0d ferr=%0d, want 0 0", n_valid, n_ferr);
      end
      send_byte(8'h42, 1'b1);
      tick(10);
      checks++;
      if (n_valid !== 1 || n_ferr !== 0 || rx_data !== 8'h42) begin
         failures++;
         $display("FAIL after_rst_42: valid=%0d ferr=%0d data=%h, want 1 0 42", n_valid, n_ferr, rx_data);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_mid_reset();
      checks++;
      if (n_both !== 0) begin
         failures++;
         $display("FAIL strobe_exclusive: both-high cycles=%0d, want 0", n_both);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
